// File: rtl/result_ascii_emitter.sv
// rtl/result_ascii_emitter.sv - binary path count to decimal ASCII line streamer
// Double-dabble conversion, then one character per consumed cycle, newline terminated.
module result_ascii_emitter #(
  parameter int NUM_PATHS_DW = 32,
  parameter int MAX_DIGITS   = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_PATHS_DW-1:0] i_result,
  input  logic                    i_result_vld,
  input  logic                    i_error,
  output logic [7:0]              o_char,
  output logic                    o_char_vld,
  input  logic                    i_stall,
  output logic                    o_busy,
  output logic                    o_overrun
);
  localparam int BW = 4 * MAX_DIGITS;
  localparam int DW = NUM_PATHS_DW;
  localparam int IW = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS) : 1;
  localparam int CW = $clog2(NUM_PATHS_DW + 1);

  typedef enum logic [2:0] {IDLE, CONVERT, EMIT, NEWLINE, ERRMSG, HALT} state_t;

  state_t         state, state_n;
  // BCD digits and the binary shift register live in one vector so the
  // double-dabble step is a single left shift across both.
  logic [BW+DW-1:0] dd, dd_n, dd_adj, dd_step;
  logic [CW-1:0]  bit_cnt, bit_cnt_n;
  logic [IW-1:0]  idx, idx_n, idx_dec, top_idx;
  logic [1:0]     err_cnt, err_cnt_n;
  logic [7:0]     char_n;
  logic           vld_n;
  logic           consumed;

  function automatic logic [3:0] nibble(input logic [BW-1:0] b, input logic [IW-1:0] i);
    nibble = 4'd0;
    for (int k = 0; k < MAX_DIGITS; k++)
      if (i == k[IW-1:0]) nibble = b[4*k +: 4];
  endfunction

  function automatic logic [7:0] err_char(input logic [1:0] n);
    case (n)
      2'd0:    err_char = 8'h45;
      2'd3:    err_char = 8'h0A;
      default: err_char = 8'h52;
    endcase
  endfunction

  assign consumed = o_char_vld && !i_stall;
  assign o_busy   = (state != IDLE) && (state != HALT);
  assign idx_dec  = idx - IW'(1);

  always_comb begin
    dd_adj = dd;
    for (int k = 0; k < MAX_DIGITS; k++)
      if (dd[DW+4*k +: 4] >= 4'd5) dd_adj[DW+4*k +: 4] = dd[DW+4*k +: 4] + 4'd3;
    dd_step = dd_adj << 1;
    top_idx = '0;
    for (int k = 0; k < MAX_DIGITS; k++)
      if (dd_step[DW+4*k +: 4] != 4'd0) top_idx = k[IW-1:0];
  end

  always_comb begin
    state_n   = state;
    dd_n      = dd;
    bit_cnt_n = bit_cnt;
    idx_n     = idx;
    err_cnt_n = err_cnt;
    char_n    = o_char;
    vld_n     = o_char_vld;
    case (state)
      IDLE: begin
        if (i_error) begin
          state_n   = ERRMSG;
          err_cnt_n = 2'd0;
          char_n    = err_char(2'd0);
          vld_n     = 1'b1;
        end else if (i_result_vld) begin
          state_n   = CONVERT;
          dd_n      = {{BW{1'b0}}, i_result};
          bit_cnt_n = CW'(NUM_PATHS_DW);
        end
      end
      CONVERT: begin
        dd_n      = dd_step;
        bit_cnt_n = bit_cnt - CW'(1);
        if (bit_cnt == CW'(1)) begin
          state_n = EMIT;
          idx_n   = top_idx;
          char_n  = 8'h30 + {4'h0, nibble(dd_step[DW +: BW], top_idx)};
          vld_n   = 1'b1;
        end
      end
      EMIT: begin
        if (consumed) begin
          if (idx == '0) begin
            state_n = NEWLINE;
            char_n  = 8'h0A;
          end else begin
            idx_n  = idx_dec;
            char_n = 8'h30 + {4'h0, nibble(dd[DW +: BW], idx_dec)};
          end
        end
      end
      NEWLINE: begin
        if (consumed) begin
          state_n = IDLE;
          char_n  = 8'h00;
          vld_n   = 1'b0;
        end
      end
      ERRMSG: begin
        if (consumed) begin
          if (err_cnt == 2'd3) begin
            state_n = HALT;
            char_n  = 8'h00;
            vld_n   = 1'b0;
          end else begin
            err_cnt_n = err_cnt + 2'd1;
            char_n    = err_char(err_cnt + 2'd1);
          end
        end
      end
      HALT: begin
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      dd         <= '0;
      bit_cnt    <= '0;
      idx        <= '0;
      err_cnt    <= '0;
      o_char     <= 8'h00;
      o_char_vld <= 1'b0;
      o_overrun  <= 1'b0;
    end else begin
      state      <= state_n;
      dd         <= dd_n;
      bit_cnt    <= bit_cnt_n;
      idx        <= idx_n;
      err_cnt    <= err_cnt_n;
      o_char     <= char_n;
      o_char_vld <= vld_n;
      // A strobe that arrives while busy is dropped; remember that it happened.
      if (i_result_vld && o_busy) o_overrun <= 1'b1;
    end
  end
endmodule

// File: tb/tb_result_ascii_emitter.sv
// tb/tb_result_ascii_emitter.sv - randomized scoreboard bench for result_ascii_emitter
module tb_result_ascii_emitter;
  localparam int DW  = 32;
  localparam int MD  = 10;
  localparam int LAT = DW + 1;

  function automatic int dec_digits(input int w);
    longint unsigned v;
    int n;
    v = (w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    n = 1;
    while (v >= 64'd10) begin
      v = v / 64'd10;
      n++;
    end
    return n;
  endfunction

  if (MD < dec_digits(DW)) begin : g_digit_check
    initial $fatal(1, "FAIL digit_check: MAX_DIGITS %0d needs %0d", MD, dec_digits(DW));
  end

  logic          clk, rst;
  logic [DW-1:0] i_result;
  logic          i_result_vld, i_error, i_stall;
  logic [7:0]    o_char;
  logic          o_char_vld, o_busy, o_overrun;

  result_ascii_emitter #(.NUM_PATHS_DW(DW), .MAX_DIGITS(MD)) dut (
    .clk(clk), .rst(rst), .i_result(i_result), .i_result_vld(i_result_vld),
    .i_error(i_error), .o_char(o_char), .o_char_vld(o_char_vld), .i_stall(i_stall),
    .o_busy(o_busy), .o_overrun(o_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         tests = 0, fails = 0, cyc = 0, m_due = 0;
  byte        exp_q[$];
  bit         m_busy = 0, m_err = 0, m_halt = 0, m_ovr = 0, m_first = 0;
  bit         prev_vld = 0, prev_stall = 0, prev_rst = 1;
  logic [7:0] prev_char = 8'h00;
  string      captured = "";
  bit         force_stall = 0, rand_stall = 0;
  time        t_acc;

  function automatic string esc(input string s);
    string r;
    r = "";
    for (int i = 0; i < s.len(); i++)
      if (s[i] == 8'h0A) r = {r, "\\n"};
      else r = {r, $sformatf("%c", s[i])};
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic chk_str(input string name, input string act, input string want);
    tests++;
    if (act != want) begin
      fails++;
      $display("FAIL %s: got \"%s\", expected \"%s\"", name, esc(act), esc(want));
    end
  endtask

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  // Scoreboard: the model only knows "a line is owed" and whether the block is taken.
  always @(negedge clk) begin
    bit busy_now, halt_now;
    cyc++;
    busy_now = m_busy;
    halt_now = m_halt;
    chk("busy", o_busy, m_busy);
    chk("overrun", o_overrun, m_ovr);
    if (prev_vld && prev_stall && !prev_rst) begin
      chk("hold_vld", o_char_vld, 1);
      chk("hold_char", o_char, prev_char);
    end
    if (o_char_vld === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_char: got 0x%0h, expected no character (cycle %0d)", o_char, cyc);
      end else begin
        if (m_first) begin
          chk("first_char_cycle", cyc, m_due);
          m_first = 0;
        end
        chk("char", o_char, exp_q[0]);
        if (i_stall === 1'b0) begin
          void'(exp_q.pop_front());
          captured = {captured, $sformatf("%c", o_char)};
          if (exp_q.size() == 0) begin
            if (m_err) m_halt = 1;
            m_busy = 0;
            m_err  = 0;
          end
        end
      end
    end else if (exp_q.size() != 0 && cyc >= m_due) begin
      chk("char_vld", o_char_vld, 1);
    end else if (exp_q.size() == 0) begin
      chk("idle_vld", o_char_vld, 0);
    end
    prev_vld   = (o_char_vld === 1'b1);
    prev_stall = (i_stall === 1'b1);
    prev_char  = o_char;
    prev_rst   = rst;

    if (rst) begin
      exp_q.delete();
      m_busy = 0; m_err = 0; m_halt = 0; m_ovr = 0; m_first = 0;
    end else if (!halt_now) begin
      if (busy_now) begin
        if (i_result_vld) m_ovr = 1;
      end else if (i_error) begin
        push_str("ERR\n");
        m_busy = 1; m_err = 1; m_first = 1; m_due = cyc + 1;
      end else if (i_result_vld) begin
        push_str($sformatf("%0d\n", i_result));
        m_busy = 1; m_first = 1; m_due = cyc + LAT;
      end
    end
  end

  always @(posedge clk) begin
    #1 i_stall = force_stall || (rand_stall && ($urandom_range(0, 2) == 0));
  end

  task automatic send(input logic [DW-1:0] v);
    @(posedge clk);
    #1 i_result = v;
    i_result_vld = 1'b1;
    t_acc = $time;
    @(posedge clk);
    #1 i_result_vld = 1'b0;
  endtask

  task automatic wait_model(input bit for_halt);
    for (int i = 0; i < 3000; i++) begin
      if (for_halt ? m_halt : (!m_busy && exp_q.size() == 0)) return;
      @(posedge clk);
      #2;
    end
    tests++;
    fails++;
    $display("FAIL wait_timeout: got no completion, expected one within 3000 cycles");
  endtask

  task automatic wait_vld(output int lat);
    lat = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (o_char_vld === 1'b1) begin
        lat = int'(($time - t_acc) / 10);
        return;
      end
    end
  endtask

  task automatic pulse_rst();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int lat;
    logic [DW-1:0] v;
    rst = 1'b1; i_result = '0; i_result_vld = 1'b0; i_error = 1'b0; i_stall = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_char", o_char, 8'h00);
    chk("rst_vld", o_char_vld, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_overrun", o_overrun, 0);

    captured = ""; send(32'd0); wait_vld(lat); chk("latency_0", lat, 33);
    wait_model(0); chk_str("line_0", captured, "0\n");
    captured = ""; send(32'd2147); wait_vld(lat); chk("latency_2147", lat, 33);
    wait_model(0); chk_str("line_2147", captured, "2147\n");
    captured = ""; send(32'hFFFF_FFFF); wait_model(0);
    chk_str("line_max", captured, "4294967295\n");

    captured = ""; send(32'd1000);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (o_char_vld === 1'b1 && o_char == 8'h31) break;
    end
    force_stall = 1;
    repeat (3) @(negedge clk);
    force_stall = 0;
    wait_model(0);
    chk_str("line_1000_stall", captured, "1000\n");

    captured = ""; send(32'd77);
    repeat (8) @(posedge clk);
    send(32'd5);
    wait_model(0);
    chk_str("line_overrun", captured, "77\n");
    chk("overrun_sticky", o_overrun, 1);

    rand_stall = 1;
    for (int n = 0; n < 25; n++) begin
      case ($urandom_range(0, 3))
        0:       v = $urandom_range(0, 9);
        1:       v = $urandom_range(0, 99999);
        2:       v = $urandom;
        default: v = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'd1_000_000_000;
      endcase
      send(v);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(0, 30)) @(posedge clk);
        send($urandom);
      end
      wait_model(0);
    end
    rand_stall = 0;
    chk("overrun_after_random", o_overrun, 1);

    send(32'd123456);
    wait_vld(lat);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_emit_rst_vld", o_char_vld, 0);
    chk("mid_emit_rst_overrun", o_overrun, 0);
    captured = ""; send(32'd8); wait_model(0);
    chk_str("line_after_rst", captured, "8\n");

    captured = ""; send(32'd42);
    repeat (5) @(posedge clk);
    #1 i_error = 1'b1;
    wait_model(1);
    chk_str("line_err_late", captured, "42\nERR\n");
    i_error = 1'b0;
    pulse_rst();

    captured = "";
    @(posedge clk);
    #1 i_error = 1'b1; i_result = 32'd55; i_result_vld = 1'b1;
    @(posedge clk);
    #1 i_error = 1'b0; i_result_vld = 1'b0;
    wait_model(1);
    send(32'd9);
    repeat (60) @(posedge clk);
    #1;
    chk_str("line_err_halt", captured, "ERR\n");
    chk("halt_busy", o_busy, 0);
    chk("halt_overrun", o_overrun, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/result_ascii_emitter.md
Name: result_ascii_emitter

Overview:
- Downstream stage of the path-counting top level: consumes the binary path count (o_result/o_result_vld) and the parse error flag (o_error).
- Converts the count to decimal ASCII with a double-dabble BCD converter and streams the characters out one per cycle, terminated by a newline.
- Output side uses the same stall handshake as the character input side of the design, so a UART/host sink can back-pressure it.

Parameters:
- NUM_PATHS_DW, 32, width of the binary result; must match the top level.
- MAX_DIGITS, 10, BCD digit count; must be >= ceil(NUM_PATHS_DW*log10(2)). Bench checks this with an elaboration-time assertion.

Ports:
- clk  input  1  clock; single clock domain.
- rst  input  1  synchronous, active-high reset.
- i_result  input  NUM_PATHS_DW  binary path count.
- i_result_vld  input  1  one-cycle strobe; i_result is valid this cycle.
- i_error  input  1  level; upstream parse error.
- o_char  output  8  ASCII character.
- o_char_vld  output  1  o_char valid.
- i_stall  input  1  sink not ready. A character is consumed on a cycle where o_char_vld=1 and i_stall=0.
- o_busy  output  1  high in any state other than IDLE or HALT.
- o_overrun  output  1  sticky; set when a result strobe arrives while busy.

Behaviour:
- States: IDLE, CONVERT, EMIT, NEWLINE, ERRMSG, HALT.
- Reset (synchronous, any state, including mid-conversion or mid-emission):
  - state returns to IDLE.
  - o_char_vld=0, o_char=8'h00, o_busy=0, o_overrun=0.
  - BCD register, shift register and counters are cleared.
- IDLE:
  - i_error=1 → ERRMSG. Error wins over a simultaneous i_result_vld.
  - Otherwise, i_result_vld=1 → latch i_result into the shift register, clear the BCD register, load bit counter = NUM_PATHS_DW → CONVERT.
- CONVERT:
  - Exactly NUM_PATHS_DW cycles, one double-dabble iteration per cycle.
  - Each iteration: every BCD nibble >=5 gets +3, then {bcd,shift} shifts left by 1.
  - No o_char_vld during CONVERT.
  - On the last iteration, compute the digit index = the most significant nonzero nibble of the final BCD value (index 0 if the value is 0) → EMIT.
- Latency:
  - Acceptance cycle = T. First o_char_vld=1 at T+NUM_PATHS_DW+1 (outputs registered).
  - With no stall, one character per cycle after that.
- EMIT:
  - o_char = 8'h30 + nibble[index]; o_char_vld=1.
  - On consumption: index 0 → NEWLINE, else index decrements.
  - Leading zeros are never emitted; value 0 emits exactly "0".
- NEWLINE: o_char=8'h0A; on consumption → IDLE with o_char_vld=0 the next cycle.
- ERRMSG:
  - Emits "ERR\n" (8'h45, 8'h52, 8'h52, 8'h0A) under the same handshake, then → HALT.
  - If i_error rises during CONVERT or EMIT, the current number and its newline finish first; ERRMSG is entered from IDLE.
- HALT: o_char_vld=0; all inputs ignored until reset.
- Stall rules:
  - While o_char_vld=1 and i_stall=1, o_char and o_char_vld hold stable.
  - i_stall has no effect in CONVERT, IDLE or HALT.
- Overrun:
  - i_result_vld while o_busy=1 is dropped (the in-flight value is unaffected) and sets o_overrun.
  - o_overrun clears only on reset.
  - A strobe in the same cycle the NEWLINE character is consumed is also dropped, since state is not yet IDLE.
- Arithmetic: all BCD arithmetic is per-nibble, 4 bits, no carry between nibbles (add-3 keeps each nibble <=15 before the shift). The BCD register is 4*MAX_DIGITS bits.

Test Plan:
- Result 0, no stall → o_char_vld at T+33 with 0x30, then 0x0A at T+34, then idle; o_busy low from T+35.
- Result 2147, no stall → 0x32,0x31,0x34,0x37,0x0A on consecutive cycles starting T+33; no leading 0x30.
- Result 32'hFFFFFFFF → "4294967295\n": 11 characters, first 0x34, last digit 0x35.
- Result 1000 with i_stall high for 3 cycles while 0x30 (second char) is presented → o_char stays 0x30 with o_char_vld=1 for 4 cycles; stream completes as "1000\n" with no duplicate or missing characters.
- Second i_result_vld (value 5) at T+10 during conversion of 77 → output "77\n" only; o_overrun=1 and stays high until rst.
- i_error and i_result_vld together in IDLE → "ERR\n" (0x45,0x52,0x52,0x0A), then HALT: a later strobe of 9 produces no output.
- rst asserted mid-EMIT of 123456 → next cycle o_char_vld=0, o_overrun=0; a fresh strobe of 8 yields "8\n".
